// File: rtl/framebuffer_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : framebuffer_scan                                                |
// | Purpose  : 3-bit colour framebuffer (FB_W x FB_H, addressed x*FB_H+y).     |
// |            After reset it clears every entry to 0. In IDLE it accepts      |
// |            pixel plots. On start it streams the whole buffer column-major  |
// |            over a valid/ready output.                                      |
// | Ports    : clk, rst (async, active-high)                                   |
// |            vga_x/vga_y/vga_colour/vga_plot -> plot write port             |
// |            plot_ready -> high only in IDLE                                 |
// |            start/done -> scan request (level) / scan complete             |
// |            out_x/out_y/out_colour/out_valid/out_ready -> pixel stream     |
// |            oob_err -> sticky out-of-range plot flag                       |
// | Config   : define FB_OOB_CHECK_EN to flag out-of-range plots on oob_err;   |
// |            otherwise they are dropped silently and oob_err is 0.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module framebuffer_scan #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  output logic       plot_ready,
  input  logic       start,
  output logic       done,
  output logic [7:0] out_x,
  output logic [6:0] out_y,
  output logic [2:0] out_colour,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       oob_err
);

  localparam int          DEPTH     = FB_W * FB_H;
  localparam logic [7:0]  X_LAST    = 8'(FB_W - 1);
  localparam logic [6:0]  Y_LAST    = 7'(FB_H - 1);
  localparam logic [14:0] ADDR_LAST = 15'(DEPTH - 1);
  localparam logic [14:0] H15       = 15'(FB_H);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        fetched_all_q, fetched_all_d;  // last pixel has been read
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_x_q, out_x_d;
  logic [6:0]  out_y_q, out_y_d;

  logic [2:0]  mem [DEPTH];
  logic [2:0]  rd_data_q;
  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;
  logic        mem_re;
  logic [14:0] mem_raddr;
  logic        plot_in_range;

  assign plot_in_range = (vga_x <= X_LAST) && (vga_y <= Y_LAST);
  assign mem_raddr     = 15'(x_q) * H15 + 15'(y_q);

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    x_d           = x_q;
    y_d           = y_q;
    fetched_all_d = fetched_all_q;
    out_valid_d   = out_valid_q;
    out_x_d       = out_x_q;
    out_y_d       = out_y_q;
    mem_we        = 1'b0;
    mem_waddr     = clr_addr_q;
    mem_wdata     = 3'd0;
    mem_re        = 1'b0;

    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        if (clr_addr_q == ADDR_LAST) begin
          clr_addr_d = 15'd0;
          state_d    = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      S_IDLE: begin
        // The plot is still written when start arrives in the same cycle.
        if (vga_plot && plot_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = 15'(vga_x) * H15 + 15'(vga_y);
          mem_wdata = vga_colour;
        end
        if (start) begin
          state_d       = S_SCAN;
          x_d           = 8'd0;
          y_d           = 7'd0;
          fetched_all_d = 1'b0;
        end
      end
      S_SCAN: begin
        // Read a new pixel whenever the output slot is empty or draining.
        if (!fetched_all_q && (!out_valid_q || out_ready)) begin
          mem_re      = 1'b1;
          out_valid_d = 1'b1;
          out_x_d     = x_q;
          out_y_d     = y_q;
          if (y_q == Y_LAST) begin
            if (x_q == X_LAST) begin
              fetched_all_d = 1'b1;  // counters park on the final pixel
            end else begin
              x_d = x_q + 8'd1;
              y_d = 7'd0;
            end
          end else begin
            y_d = y_q + 7'd1;
          end
        end else if (out_valid_q && out_ready) begin
          // Only the final pixel can drain without a refill.
          out_valid_d = 1'b0;
          if (fetched_all_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      clr_addr_q    <= 15'd0;
      x_q           <= 8'd0;
      y_q           <= 7'd0;
      fetched_all_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_x_q       <= 8'd0;
      out_y_q       <= 7'd0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fetched_all_q <= fetched_all_d;
      out_valid_q   <= out_valid_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
    end
  end

  // Storage has no reset so it maps onto block RAM; CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_data_q <= mem[mem_raddr];
    end
  end

`ifdef FB_OOB_CHECK_EN
  logic oob_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oob_err_q <= 1'b0;
    end else if ((state_q == S_IDLE) && vga_plot && !plot_in_range) begin
      oob_err_q <= 1'b1;
    end
  end

  assign oob_err = oob_err_q;
`else
  assign oob_err = 1'b0;
`endif

  assign plot_ready = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  // Gate with valid so the unreset read register never shows through.
  assign out_colour = out_valid_q ? rd_data_q : 3'd0;

endmodule
`default_nettype wire

// File: doc/framebuffer_scan.md
FRAMEBUFFER_SCAN -- requirements
Module: framebuffer_scan

Interface
REQ-001 Parameter: FB_W, 160, framebuffer width in pixels.
REQ-002 Parameter: FB_H, 120, framebuffer height in pixels.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: vga_x  input  8  plot column.
REQ-006 Port: vga_y  input  7  plot row.
REQ-007 Port: vga_colour  input  3  plot colour.
REQ-008 Port: vga_plot  input  1  plot strobe; one write per cycle when high.
REQ-009 Port: plot_ready  output  1  high only in IDLE; plots are accepted only when high.
REQ-010 Port: start  input  1  scan-out request (level).
REQ-011 Port: done  output  1  scan complete; held until start low.
REQ-012 Port: out_x  output  8  scanned pixel column.
REQ-013 Port: out_y  output  7  scanned pixel row.
REQ-014 Port: out_colour  output  3  scanned pixel colour.
REQ-015 Port: out_valid  output  1  out_* carry a valid pixel.
REQ-016 Port: out_ready  input  1  downstream accepts pixel when out_valid and out_ready are both high.
REQ-017 Port: oob_err  output  1  sticky out-of-range plot flag (see Configuration).

Function
REQ-018 The block SHALL store FB_W*FB_H 3-bit entries, addressed x*FB_H+y, in a synchronous single-read-port memory with 1-cycle read latency.
REQ-019 The state machine SHALL have states CLEAR, IDLE, SCAN and DONE.
REQ-020 In CLEAR, the block SHALL write colour 0 to one address per cycle, ascending, for FB_W*FB_H cycles, then go to IDLE.
REQ-021 In IDLE, vga_plot high with in-range coordinates SHALL write vga_colour at (vga_x,vga_y) that edge; a same-cycle start has priority, with the write still performed.
REQ-022 vga_plot SHALL be ignored in CLEAR, SCAN and DONE (no write).
REQ-023 In IDLE with start high, the block SHALL enter SCAN next edge with the scan counter at (0,0).
REQ-024 SCAN order SHALL be column-major: y increments 0..FB_H-1 within each x; x increments 0..FB_W-1.
REQ-025 First out_valid SHALL assert exactly 1 cycle after entering SCAN.
REQ-026 Pixels SHALL then stream at one per cycle while out_ready is high.
REQ-027 While out_valid is high and out_ready is low, out_x/out_y/out_colour/out_valid SHALL hold stable and the counter SHALL not advance.
REQ-028 On the handshake of pixel (FB_W-1,FB_H-1), the block SHALL go to DONE next edge: out_valid low, done high.
REQ-029 In DONE, done SHALL stay high while start is high and SHALL drop one cycle after start goes low, returning to IDLE.
REQ-030 Deasserting start during SCAN SHALL not abort the scan.
REQ-031 Memory contents SHALL persist across scans; only CLEAR erases them.
REQ-032 Counters SHALL be sized exactly (8-bit x, 7-bit y, 15-bit address) with no wrap beyond the limits.

Reset
REQ-033 rst high SHALL immediately force state=CLEAR, with counters, out_*, out_valid, done and plot_ready all 0 and oob_err 0, including mid-SCAN or mid-CLEAR.
REQ-034 After rst falls, the block SHALL run the full CLEAR and keep plot_ready low throughout.

Configuration
REQ-035 With FB_OOB_CHECK_EN defined, an IDLE plot with vga_x>=FB_W or vga_y>=FB_H SHALL be dropped and set oob_err, which is sticky until rst.
REQ-036 Without FB_OOB_CHECK_EN, out-of-range plots SHALL be dropped silently and oob_err SHALL be tied to 0.

Verification
REQ-037 Pulse rst, release -> plot_ready 0 for 19200 cycles then 1; immediate scan with out_ready=1 -> 19200 pixels, all colour 0.
REQ-038 Plot (0,0)=4, (159,119)=7, (10,5)=2 in IDLE, then scan with out_ready=1 -> first out_valid 1 cycle after SCAN entry, pixel 1205 is colour 2, last pixel (159,119)=7, done high the next cycle.
REQ-039 Mid-scan, hold out_ready=0 for 5 cycles at pixel (3,7) -> out_* stable for 5 cycles; pixel count still 19200.
REQ-040 Hold start high after done -> done stays 1; drop start -> done 0 the following cycle, plot_ready 1.
REQ-041 Assert rst mid-SCAN at pixel 500 -> out_valid and done 0 immediately; full CLEAR reruns, then a scan returns all zeros.
REQ-042 With FB_OOB_CHECK_EN, plot (160,0)=5 -> oob_err 1 (sticky) and no memory change; without the macro -> oob_err stays 0.
